// File: rtl/axil2apb_bridge_mc_if.sv
// Bus bundle for the AXI-Lite to multi-slave APB bridge.
// Carries both the upstream AXI-Lite channels and the downstream APB
// signals so the bridge and its environment connect through one instance.
//   slave  : the bridge view (AXI-Lite slave towards the CPU side, APB
//            master towards the peripherals)
//   master : the environment view (drives AXI-Lite requests and APB
//            slave responses)
interface axil2apb_bridge_mc_if #(
  parameter int AXI_LITE_AW = 32,
  parameter int AXI_LITE_DW = 32,
  parameter int APB_AW      = 32,
  parameter int N_SLV       = 4
);
  // AXI-Lite write address / data / response
  logic [AXI_LITE_AW-1:0]     awaddr;
  logic [2:0]                 awprot;
  logic                       awvalid;
  logic                       awready;
  logic [AXI_LITE_DW-1:0]     wdata;
  logic [AXI_LITE_DW/8-1:0]   wstrb;
  logic                       wvalid;
  logic                       wready;
  logic [1:0]                 bresp;
  logic                       bvalid;
  logic                       bready;
  // AXI-Lite read address / data
  logic [AXI_LITE_AW-1:0]     araddr;
  logic [2:0]                 arprot;
  logic                       arvalid;
  logic                       arready;
  logic [AXI_LITE_DW-1:0]     rdata;
  logic [1:0]                 rresp;
  logic                       rvalid;
  logic                       rready;
  // APB master side, one psel/pready/pslverr/prdata lane per slave
  logic [APB_AW-1:0]          paddr;
  logic [2:0]                 pprot;
  logic                       pwrite;
  logic [AXI_LITE_DW-1:0]     pwdata;
  logic [AXI_LITE_DW/8-1:0]   pstrb;
  logic [N_SLV-1:0]           psel;
  logic                       penable;
  logic [N_SLV*AXI_LITE_DW-1:0] prdata;
  logic [N_SLV-1:0]           pready;
  logic [N_SLV-1:0]           pslverr;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready,
    output paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
    input  prdata, pready, pslverr
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready,
    input  paddr, pprot, pwrite, pwdata, pstrb, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/axil2apb_bridge_mc.sv
// AXI-Lite slave to N-slave APB master bridge.
// One transfer in flight; write/read arbitrated round-robin in IDLE.
// Each APB slave owns a 2**SLV_WIN_LOG2 byte window starting at PERIPH_BA;
// anything outside the map answers DECERR without touching APB.
// Optional build macro AXIL2APB_TIMEOUT_EN: aborts an ACCESS phase with
// SLVERR / 32'hDEAD_BEEF after TIMEOUT_CYC cycles without pready.
module axil2apb_bridge_mc #(
  parameter int                     AXI_LITE_AW  = 32,
  parameter int                     AXI_LITE_DW  = 32,
  parameter int                     APB_AW       = 32,
  parameter logic [AXI_LITE_AW-1:0] PERIPH_BA    = '0,
  parameter int                     N_SLV        = 4,
  parameter int                     SLV_WIN_LOG2 = 12,
  parameter int                     TIMEOUT_CYC  = 256
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  axil2apb_bridge_mc_if.slave  bus
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [AXI_LITE_AW-1:0] WIN_MASK =
    AXI_LITE_AW'((64'd1 << SLV_WIN_LOG2) - 64'd1);

  if (AXI_LITE_DW != 32) begin : g_dw_check
    $error("axil2apb_bridge_mc: AXI_LITE_DW must be 32");
  end
  if (APB_AW > AXI_LITE_AW) begin : g_aw_check
    $error("axil2apb_bridge_mc: APB_AW must not exceed AXI_LITE_AW");
  end
  if (N_SLV < 1 || N_SLV > 16) begin : g_nslv_check
    $error("axil2apb_bridge_mc: N_SLV must be 1..16");
  end
  if (TIMEOUT_CYC < 1) begin : g_to_check
    $error("axil2apb_bridge_mc: TIMEOUT_CYC must be positive");
  end

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP_W, RESP_R} state_e;

  state_e                   state_q, state_d;
  logic                     rr_wr_q;
  logic                     is_wr_q;
  logic [IDX_W-1:0]         idx_q;
  logic [APB_AW-1:0]        paddr_q;
  logic [2:0]               pprot_q;
  logic [AXI_LITE_DW-1:0]   pwdata_q;
  logic [AXI_LITE_DW/8-1:0] pstrb_q;
  logic [1:0]               resp_q;
  logic [AXI_LITE_DW-1:0]   rdata_q;

  logic                     wr_req, rd_req, wr_pick;
  logic                     wr_grant, rd_grant;
  logic [AXI_LITE_AW-1:0]   req_addr, req_off, req_idx_full;
  logic                     dec_err;
  logic                     sel_ready, sel_err, to_hit;
  logic [AXI_LITE_DW-1:0]   sel_rdata;

  assign wr_req       = bus.awvalid & bus.wvalid;
  assign rd_req       = bus.arvalid;
  assign wr_pick      = wr_req & (~rd_req | rr_wr_q);
  assign req_addr     = wr_pick ? bus.awaddr : bus.araddr;
  assign req_off      = req_addr - PERIPH_BA;
  assign req_idx_full = req_off >> SLV_WIN_LOG2;
  assign dec_err      = (req_addr < PERIPH_BA) ||
                        (req_idx_full >= AXI_LITE_AW'(N_SLV));

  assign sel_ready = bus.pready[idx_q];
  assign sel_err   = bus.pslverr[idx_q];
  assign sel_rdata = bus.prdata[idx_q*AXI_LITE_DW +: AXI_LITE_DW];

`ifdef AXIL2APB_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYC + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  logic [TO_W-1:0] to_cnt_q;

  // The count reaches TIMEOUT_CYC at the edge closing the TIMEOUT_CYC-th ACCESS cycle
  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  // ACCESS cycle counter, cleared while in SETUP so it starts at zero on entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and accept handshakes; decode errors skip the APB phases
  always_comb begin
    state_d  = state_q;
    wr_grant = 1'b0;
    rd_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pick) begin
          wr_grant = 1'b1;
          state_d  = dec_err ? RESP_W : SETUP;
        end else if (rd_req) begin
          rd_grant = 1'b1;
          state_d  = dec_err ? RESP_R : SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: if (sel_ready || to_hit) state_d = is_wr_q ? RESP_W : RESP_R;
      RESP_W: if (bus.bready) state_d = IDLE;
      RESP_R: if (bus.rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture at accept, response capture at the end of ACCESS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_wr_q  <= 1'b1;
      is_wr_q  <= 1'b0;
      idx_q    <= '0;
      paddr_q  <= '0;
      pprot_q  <= '0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      resp_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (wr_grant || rd_grant) begin
        is_wr_q  <= wr_grant;
        idx_q    <= IDX_W'(req_idx_full);
        paddr_q  <= APB_AW'(req_off & WIN_MASK);
        pprot_q  <= wr_grant ? bus.awprot : bus.arprot;
        pwdata_q <= wr_grant ? bus.wdata : '0;
        pstrb_q  <= wr_grant ? bus.wstrb : '0;
        resp_q   <= dec_err ? 2'b11 : 2'b00;
        rdata_q  <= '0;
        if (wr_req && rd_req) rr_wr_q <= ~rr_wr_q;
      end
      if (state_q == ACCESS) begin
        if (sel_ready) begin
          resp_q  <= sel_err ? 2'b10 : 2'b00;
          rdata_q <= is_wr_q ? '0 : sel_rdata;
        end else if (to_hit) begin
          resp_q  <= 2'b10;
          rdata_q <= is_wr_q ? '0 : AXI_LITE_DW'(32'hDEAD_BEEF);
        end
      end
    end
  end

  assign bus.awready = wr_grant;
  assign bus.wready  = wr_grant;
  assign bus.arready = rd_grant;
  assign bus.bvalid  = (state_q == RESP_W);
  assign bus.rvalid  = (state_q == RESP_R);
  assign bus.bresp   = resp_q;
  assign bus.rresp   = resp_q;
  assign bus.rdata   = rdata_q;

  assign bus.psel    = ((state_q == SETUP) || (state_q == ACCESS)) ?
                       (N_SLV'(1) << idx_q) : '0;
  assign bus.penable = (state_q == ACCESS);
  assign bus.paddr   = paddr_q;
  assign bus.pprot   = pprot_q;
  assign bus.pwrite  = is_wr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.pstrb   = pstrb_q;

endmodule
